// File: rtl/alu_pkg.sv
// ============================================================================
//  Module   : alu_pkg
//  Desc     : ALU control codes and execute-stage FSM encoding shared by the
//             ALU control decoder and alu_ex_stage.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package alu_pkg;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_SLL = 4'b1111;
    localparam logic [3:0] ALU_JR  = 4'b1000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_HOLD  = 2'd2
    } alu_state_e;

endpackage

`default_nettype wire

// File: rtl/alu_shift_seq.sv
// ============================================================================
//  Module   : alu_shift_seq
//  Desc     : Iterative one-bit-per-cycle left shifter with SHIFT/HOLD
//             sequencing; only used when ALU_FAST_SHIFT_EN is undefined.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_shift_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic [WIDTH-1:0] operand_i,
    input  logic [4:0]       shamt_i,
    input  logic             out_free_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] result_o
);

    alu_state_e       state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [4:0]       cnt_q, cnt_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        done_o   = 1'b0;
        result_o = acc_q;
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    acc_d   = operand_i;
                    cnt_d   = shamt_i;
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                acc_d = acc_q << 1;
                cnt_d = cnt_q - 5'd1;
                // Final step: hand the shifted value straight out if possible,
                // otherwise park it (already shifted) in acc for HOLD.
                if (cnt_q == 5'd1) begin
                    if (out_free_i) begin
                        done_o   = 1'b1;
                        result_o = acc_q << 1;
                        state_d  = ST_IDLE;
                    end else begin
                        state_d  = ST_HOLD;
                    end
                end
            end
            ST_HOLD: begin
                if (out_free_i) begin
                    done_o  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign busy_o = (state_q != ST_IDLE);

endmodule

`default_nettype wire

// File: rtl/alu_ex_stage.sv
// ============================================================================
//  Module   : alu_ex_stage
//  Desc     : Execute-stage ALU with valid/ready handshake and registered
//             result. Define ALU_FAST_SHIFT_EN for a single-cycle barrel SLL.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_ex_stage
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       alu_ctrl,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic [4:0]       shamt,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             jr,
    output logic             illegal
);

    logic             out_valid_q;
    logic [WIDTH-1:0] result_q;
    logic             zero_q, jr_q, illegal_q;

    logic             out_free;
    logic             accept;
    logic             multi_op;
    logic             seq_busy, seq_done;
    logic [WIDTH-1:0] seq_result;

    logic [WIDTH-1:0] alu_res;
    logic             alu_jr, alu_ill;
    logic [WIDTH-1:0] res_sel;
    logic             jr_sel, ill_sel, load;

    assign out_free = !out_valid_q || out_ready;
    assign in_ready = rst_n && !seq_busy && out_free;
    assign accept   = in_valid && in_ready;

`ifdef ALU_FAST_SHIFT_EN
    assign multi_op   = 1'b0;
    assign seq_busy   = 1'b0;
    assign seq_done   = 1'b0;
    assign seq_result = '0;
`else
    // A zero-length SLL is just op_b and goes through the single-cycle path.
    assign multi_op = (alu_ctrl == ALU_SLL) && (shamt != 5'd0);

    alu_shift_seq #(
        .WIDTH (WIDTH)
    ) u_shift_seq (
        .clk        (clk),
        .rst_n      (rst_n),
        .start_i    (accept && multi_op),
        .operand_i  (op_b),
        .shamt_i    (shamt),
        .out_free_i (out_free),
        .busy_o     (seq_busy),
        .done_o     (seq_done),
        .result_o   (seq_result)
    );
`endif

    always_comb begin
        alu_res = '0;
        alu_jr  = 1'b0;
        alu_ill = 1'b0;
        case (alu_ctrl)
            ALU_AND: alu_res = op_a & op_b;
            ALU_OR:  alu_res = op_a | op_b;
            ALU_ADD: alu_res = op_a + op_b;
            ALU_SUB: alu_res = op_a - op_b;
            ALU_SLT: alu_res = {{(WIDTH-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
            ALU_SLL: alu_res = op_b << shamt;
            ALU_JR: begin
                alu_res = op_a;
                alu_jr  = 1'b1;
            end
            default: alu_ill = 1'b1;
        endcase
    end

    // The shifter only completes while idle-side accepts are blocked, so the
    // two load sources never collide.
    always_comb begin
        res_sel = alu_res;
        jr_sel  = alu_jr;
        ill_sel = alu_ill;
        if (seq_done) begin
            res_sel = seq_result;
            jr_sel  = 1'b0;
            ill_sel = 1'b0;
        end
    end

    assign load = (accept && !multi_op) || seq_done;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            result_q    <= '0;
            zero_q      <= 1'b0;
            jr_q        <= 1'b0;
            illegal_q   <= 1'b0;
        end else if (load) begin
            out_valid_q <= 1'b1;
            result_q    <= res_sel;
            zero_q      <= (res_sel == '0);
            jr_q        <= jr_sel;
            illegal_q   <= ill_sel;
        end else if (out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign zero      = zero_q;
    assign jr        = jr_q;
    assign illegal   = illegal_q;

endmodule

`default_nettype wire

// File: tb/tb_alu_ex_stage.sv
// ============================================================================
//  Module   : tb_alu_ex_stage
//  Desc     : Scoreboard testbench for alu_ex_stage (default iterative build).
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_ex_stage;

    localparam logic [3:0] C_AND = 4'b0000;
    localparam logic [3:0] C_OR  = 4'b0001;
    localparam logic [3:0] C_ADD = 4'b0010;
    localparam logic [3:0] C_SUB = 4'b0110;
    localparam logic [3:0] C_SLT = 4'b0111;
    localparam logic [3:0] C_SLL = 4'b1111;
    localparam logic [3:0] C_JR  = 4'b1000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [3:0]  alu_ctrl = '0;
    logic [31:0] op_a = '0;
    logic [31:0] op_b = '0;
    logic [4:0]  shamt = '0;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        zero, jr, illegal;

    logic        out_ready_man = 1'b0;
    logic        rnd_ready = 1'b0;
    logic        rnd_bit = 1'b1;
    assign out_ready = rnd_ready ? rnd_bit : out_ready_man;

    alu_ex_stage #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .alu_ctrl  (alu_ctrl),
        .op_a      (op_a),
        .op_b      (op_b),
        .shamt     (shamt),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero      (zero),
        .jr        (jr),
        .illegal   (illegal)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1;
        if (rnd_ready) rnd_bit = ($urandom_range(0, 3) != 0);
    end

    typedef struct {
        logic [31:0] res;
        logic        z;
        logic        j;
        logic        il;
        int          acc_cyc;
        bit          lat;
        int          lat_exp;
    } exp_t;

    exp_t sbq[$];
    exp_t mon_e;
    int   n_chk = 0;
    int   n_fail = 0;
    bit   lat_en = 1'b0;

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic exp_t model(input logic [3:0] c, input logic [31:0] a,
                                   input logic [31:0] b, input logic [4:0] s);
        exp_t e;
        e.res = 32'h0; e.j = 1'b0; e.il = 1'b0;
        case (c)
            C_AND: e.res = a & b;
            C_OR:  e.res = a | b;
            C_ADD: e.res = a + b;
            C_SUB: e.res = a - b;
            C_SLT: e.res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            C_SLL: e.res = b << s;
            C_JR:  begin e.res = a; e.j = 1'b1; end
            default: e.il = 1'b1;
        endcase
        e.z = (e.res == 32'h0);
        e.lat_exp = (c == C_SLL && s != 5'd0) ? int'(s) + 1 : 1;
        e.acc_cyc = 0;
        e.lat = 1'b0;
        return e;
    endfunction

    // Transfers are observed mid-cycle, one half-period before the edge that commits them.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (sbq.size() == 0) begin
                chk_eq("spurious_out", {31'b0, out_valid}, 32'h0);
            end else begin
                mon_e = sbq.pop_front();
                chk_eq("result", result, mon_e.res);
                chk_eq("zero", {31'b0, zero}, {31'b0, mon_e.z});
                chk_eq("jr", {31'b0, jr}, {31'b0, mon_e.j});
                chk_eq("illegal", {31'b0, illegal}, {31'b0, mon_e.il});
                if (mon_e.lat) chk_eq("latency", cyc - mon_e.acc_cyc, mon_e.lat_exp);
            end
        end
        if (rst_n && in_valid && in_ready) begin
            mon_e = model(alu_ctrl, op_a, op_b, shamt);
            mon_e.acc_cyc = cyc;
            mon_e.lat = lat_en;
            sbq.push_back(mon_e);
        end
    end

    // Called and returns just after a rising edge; leaves in_valid asserted.
    task automatic send(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] s, output int waits);
        alu_ctrl = c; op_a = a; op_b = b; shamt = s; in_valid = 1'b1;
        waits = 0;
        @(negedge clk);
        while (!in_ready && waits < 100) begin
            waits++;
            @(negedge clk);
        end
        if (!in_ready) chk_eq("accept_timeout", {31'b0, in_ready}, 32'h1);
        @(posedge clk); #1;
    endtask

    task automatic drain();
        int t = 0;
        while (sbq.size() != 0 && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (sbq.size() != 0) chk_eq("drain_timeout", sbq.size(), 0);
        @(posedge clk); #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int w, w2, low, cnt;
        logic [3:0] codes[8];
        logic [3:0] c;
        logic [4:0] s;
        codes = '{C_AND, C_OR, C_ADD, C_SUB, C_SLT, C_SLL, C_JR, 4'b0101};

        // Reset values
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_eq("rst_in_ready", {31'b0, in_ready}, 32'h0);
        chk_eq("rst_out_valid", {31'b0, out_valid}, 32'h0);
        chk_eq("rst_result", result, 32'h0);
        chk_eq("rst_flags", {29'b0, zero, jr, illegal}, 32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk_eq("post_rst_in_ready", {31'b0, in_ready}, 32'h1);
        @(posedge clk); #1;

        // ADD with one-cycle latency
        out_ready_man = 1'b1;
        lat_en = 1'b1;
        send(C_ADD, 32'd5, 32'd7, 5'd0, w);
        in_valid = 1'b0;
        drain();

        // SUB then SLT back-to-back, no stall
        send(C_SUB, 32'd3, 32'd3, 5'd0, w);
        send(C_SLT, 32'hFFFF_FFFF, 32'd1, 5'd0, w2);
        in_valid = 1'b0;
        chk_eq("b2b_wait_sub", w, 0);
        chk_eq("b2b_wait_slt", w2, 0);
        drain();

        // SLL by 31: in_ready low for exactly 31 cycles
        send(C_SLL, 32'd0, 32'd1, 5'd31, w);
        in_valid = 1'b0;
        low = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (in_ready) break;
            low++;
        end
        chk_eq("sll31_stall", low, 31);
        @(posedge clk); #1;
        drain();

        // Blocked downstream: earlier result held stable, SLL waits, then drain+accept in one edge
        lat_en = 1'b0;
        out_ready_man = 1'b0;
        send(C_ADD, 32'd1, 32'd1, 5'd0, w);
        alu_ctrl = C_SLL; op_a = 32'd0; op_b = 32'd3; shamt = 5'd4;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk_eq("hold_valid", {31'b0, out_valid}, 32'h1);
            chk_eq("hold_result", result, 32'd2);
            chk_eq("hold_in_ready", {31'b0, in_ready}, 32'h0);
        end
        @(posedge clk); #1;
        out_ready_man = 1'b1;
        send(C_SLL, 32'd0, 32'd3, 5'd4, w);
        in_valid = 1'b0;
        out_ready_man = 1'b0;
        repeat (8) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            chk_eq("sll_held_valid", {31'b0, out_valid}, 32'h1);
            chk_eq("sll_held_result", result, 32'h30);
            @(negedge clk);
        end
        @(posedge clk); #1;
        out_ready_man = 1'b1;
        drain();

        // JR and an unlisted code
        lat_en = 1'b1;
        send(C_JR, 32'h0040_0020, 32'h1234_5678, 5'd0, w);
        send(4'b0101, 32'hDEAD_BEEF, 32'h1, 5'd3, w);
        in_valid = 1'b0;
        drain();

        // Reset in the middle of a 10-cycle shift
        send(C_SLL, 32'd0, 32'd1, 5'd10, w);
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        sbq.delete();
        @(negedge clk);
        chk_eq("midrst_out_valid", {31'b0, out_valid}, 32'h0);
        chk_eq("midrst_in_ready", {31'b0, in_ready}, 32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk_eq("midrst_idle", {31'b0, in_ready}, 32'h1);
        cnt = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (out_valid) cnt++;
        end
        chk_eq("midrst_no_partial", cnt, 0);
        @(posedge clk); #1;

        // Random mix with random downstream backpressure
        lat_en = 1'b0;
        rnd_ready = 1'b1;
        for (int n = 0; n < 40; n++) begin
            c = codes[$urandom_range(0, 7)];
            s = (c == C_SLL) ? 5'($urandom_range(0, 6)) : 5'($urandom_range(0, 31));
            send(c, $urandom, $urandom, s, w);
            if ($urandom_range(0, 3) == 0) begin
                in_valid = 1'b0;
                @(posedge clk); #1;
            end
        end
        in_valid = 1'b0;
        rnd_ready = 1'b0;
        out_ready_man = 1'b1;
        drain();

        chk_eq("queue_empty", sbq.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
